// File: rtl/alu_7bit_shl_seq.sv
// Multi-cycle 7-bit ALU: bitwise NOT (one cycle) and logical left shift by B,
// iterated one bit position per clock. Valid/ready handshake on both sides.
// All outputs (result, ZF, in_ready, out_valid) come straight from registers.
module alu_7bit_shl_seq #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned CNTW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ZF
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t            state_q;
    logic [CNTW-1:0]   cnt_q;
    logic [CNTW-1:0]   amt;
    logic [WIDTH-1:0]  not_a;
    logic [WIDTH-1:0]  shifted;

    // Shift amount clamped on the full B: anything >= WIDTH clears every bit anyway.
    always_comb begin
        amt     = (B >= WIDTH'(WIDTH)) ? CNTW'(WIDTH) : B[CNTW-1:0];
        not_a   = ~A;
        shifted = {result[WIDTH-2:0], 1'b0};
    end

    // Control FSM with registered result, flag and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            result    <= '0;
            ZF        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (!OP) begin
                            result    <= not_a;
                            ZF        <= (not_a == '0);
                            out_valid <= 1'b1;
                            state_q   <= StDone;
                        end else if (amt == '0) begin
                            result    <= A;
                            ZF        <= (A == '0);
                            out_valid <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            result  <= A;
                            cnt_q   <= amt;
                            state_q <= StShift;
                        end
                    end
                end
                StShift: begin
                    result <= shifted;
                    cnt_q  <= cnt_q - 1'b1;
                    // Last shift: ZF must reflect the value being written now.
                    if (cnt_q == CNTW'(1)) begin
                        ZF        <= (shifted == '0);
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    // Result and ZF hold until the consumer takes them.
                    if (out_ready) begin
                        ZF        <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    ZF        <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule
